// File: rtl/snoop_cache_ctrl_mb_if.sv
// snoop_cache_ctrl_mb_if: ACE snoop channels (AC address, CR response, CD data)
// between the interconnect (master) and the snoop controller (slave).
interface snoop_cache_ctrl_mb_if #(
   parameter int unsigned DataWidth = 64
) ();
   logic                 ac_valid_i;
   logic                 ac_ready_o;
   logic [63:0]          ac_addr_i;
   logic [3:0]           ac_snoop_i;
   logic                 cr_valid_o;
   logic                 cr_ready_i;
   logic [4:0]           cr_resp_o;
   logic                 cd_valid_o;
   logic                 cd_ready_i;
   logic [DataWidth-1:0] cd_data_o;
   logic                 cd_last_o;

   modport master (
      output ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
      input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
   );

   modport slave (
      input  ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
      output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
   );
endinterface

// File: rtl/snoop_cache_ctrl_mb.sv
// snoop_cache_ctrl_mb: snoop-side D$ controller for multi-beat lines and N ways.
// Accepts one AC snoop at a time, looks up tag/flags through the shared SRAM
// port (req_o/gnt_i), updates flags and answers with CR plus a multi-beat CD.
// Optional feature macro: SNOOP_PERF_CNT_EN adds saturating hit/miss counters
// on perf_hit_o / perf_miss_o.
module snoop_cache_ctrl_mb #(
   parameter int unsigned NumWays     = 4,
   parameter int unsigned LineWidth   = 128,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned IndexWidth  = 12,
   parameter int unsigned TagWidth    = 44,
   parameter int unsigned OffsetWidth = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           bypass_i,
   output logic                           busy_o,
   snoop_cache_ctrl_mb_if.slave           snp,
   output logic [NumWays-1:0]             req_o,
   output logic [IndexWidth-1:0]          addr_o,
   output logic [TagWidth-1:0]            tag_o,
   input  logic                           gnt_i,
   input  logic [NumWays*LineWidth-1:0]   data_i,
   input  logic [NumWays-1:0]             hit_way_i,
   input  logic [NumWays-1:0]             dirty_way_i,
   input  logic [NumWays-1:0]             shared_way_i,
   output logic                           we_o,
   output logic [NumWays-1:0]             wway_o,
   output logic [2:0]                     wflags_o,
   output logic                           invalidate_o,
   output logic [63:0]                    invalidate_addr_o,
   input  logic                           flushing_i,
   input  logic                           updating_cache_i,
   input  logic                           amo_valid_i,
   input  logic [63:0]                    amo_addr_i,
   output logic                           rs_done_valid_o,
   output logic [63:0]                    rs_done_addr_o
`ifdef SNOOP_PERF_CNT_EN
   ,
   output logic [31:0]                    perf_hit_o,
   output logic [31:0]                    perf_miss_o
`endif
);

   localparam int unsigned Beats = LineWidth / DataWidth;
   localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
   localparam logic [BeatW-1:0] LAST_BEAT = BeatW'(Beats - 1);

   localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
   localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
   localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
   localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
   localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
   localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
   localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

   typedef enum logic [2:0] {IDLE, WAIT_GNT, EVAL, UPD, RESP} state_e;

   function automatic logic is_supported(input logic [3:0] snoop);
      case (snoop)
         SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_UNIQUE,
         SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID: is_supported = 1'b1;
         default:                                               is_supported = 1'b0;
      endcase
   endfunction

   state_e                           state_r, state_s;
   logic [IndexWidth-1:0]            index_r;
   logic [TagWidth-1:0]              tag_r;
   logic [3:0]                       snoop_r;
   logic [NumWays-1:0]               hit_way_r;
   logic [4:0]                       resp_r;
   logic [2:0]                       wflags_r;
   logic                             inv_r;
   logic [Beats-1:0][DataWidth-1:0]  buf_r;
   logic [BeatW-1:0]                 beat_r;
   logic                             cr_done_r;
   logic                             cd_done_r;

   logic                             same_line_s;
   logic                             accept_s;
   logic                             direct_s;
   logic                             hit_s;
   logic                             dirty_s;
   logic                             shared_s;
   logic [LineWidth-1:0]             line_s;
   logic [4:0]                       eval_resp_s;
   logic                             eval_wr_s;
   logic [2:0]                       eval_flags_s;
   logic                             eval_inv_s;
   logic                             cr_fire_s;
   logic                             cd_fire_s;
   logic                             last_s;
   logic                             cr_fin_s;
   logic                             cd_fin_s;
   logic [63:0]                      line_addr_s;
   logic                             unused_s;

   // Only line-granular AMO address bits take part in the blocking compare.
   assign unused_s    = ^amo_addr_i[OffsetWidth-1:0];

   assign same_line_s = amo_valid_i &
                        (amo_addr_i[63:OffsetWidth] == snp.ac_addr_i[63:OffsetWidth]);
   assign accept_s    = (state_r == IDLE) & snp.ac_valid_i & ~flushing_i & ~same_line_s;
   assign direct_s    = bypass_i | ~is_supported(snp.ac_snoop_i);

   assign hit_s       = |hit_way_i;
   assign dirty_s     = |(hit_way_i & dirty_way_i);
   assign shared_s    = |(hit_way_i & shared_way_i);
   assign line_addr_s = 64'({tag_r, index_r});

   assign cr_fire_s   = snp.cr_valid_o & snp.cr_ready_i;
   assign cd_fire_s   = snp.cd_valid_o & snp.cd_ready_i;
   assign last_s      = (beat_r == LAST_BEAT);
   assign cr_fin_s    = cr_done_r | cr_fire_s;
   assign cd_fin_s    = cd_done_r | ~resp_r[0] | (cd_fire_s & last_s);

   // Select the line of the (one-hot) hit way for the data buffer.
   always_comb begin
      line_s = '0;
      for (int w = 0; w < NumWays; w++) begin
         if (hit_way_i[w]) begin
            line_s = line_s | data_i[w*LineWidth +: LineWidth];
         end else begin
            line_s = line_s;
         end
      end
   end

   // Decode the response and flag update for the looked-up line.
   always_comb begin
      eval_resp_s  = 5'b00000;
      eval_wr_s    = 1'b0;
      eval_flags_s = 3'b000;
      eval_inv_s   = 1'b0;
      if (hit_s) begin
         case (snoop_r)
            SNP_READ_ONCE, SNP_READ_CLEAN: begin
               eval_resp_s = {1'b0, shared_s, 1'b0, 1'b0, 1'b1};
            end
            SNP_READ_SHARED: begin
               eval_resp_s  = {1'b0, 1'b1, dirty_s, 1'b0, 1'b1};
               eval_wr_s    = 1'b1;
               eval_flags_s = 3'b101;
            end
            SNP_READ_UNIQUE: begin
               eval_resp_s = {~shared_s, 1'b0, dirty_s, 1'b0, 1'b1};
               eval_wr_s   = 1'b1;
               eval_inv_s  = 1'b1;
            end
            SNP_CLEAN_SHARED: begin
               eval_resp_s  = {1'b0, 1'b1, dirty_s, 1'b0, dirty_s};
               eval_wr_s    = 1'b1;
               eval_flags_s = {1'b1, 1'b0, shared_s};
            end
            SNP_CLEAN_INVALID: begin
               eval_resp_s = {1'b0, 1'b0, dirty_s, 1'b0, dirty_s};
               eval_wr_s   = 1'b1;
               eval_inv_s  = 1'b1;
            end
            SNP_MAKE_INVALID: begin
               eval_wr_s  = 1'b1;
               eval_inv_s = 1'b1;
            end
            default: begin
               eval_resp_s = 5'b00000;
            end
         endcase
      end else begin
         eval_resp_s = 5'b00000;
      end
   end

   // Next state and SRAM request / flag write strobes.
   always_comb begin
      state_s      = state_r;
      req_o        = '0;
      we_o         = 1'b0;
      wway_o       = '0;
      wflags_o     = 3'b000;
      invalidate_o = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (direct_s) begin
                  state_s = RESP;
               end else begin
                  state_s = WAIT_GNT;
                  req_o   = updating_cache_i ? '0 : '1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_GNT: begin
            req_o = updating_cache_i ? '0 : '1;
            if (gnt_i) begin
               state_s = EVAL;
            end else begin
               state_s = WAIT_GNT;
            end
         end
         EVAL: begin
            req_o = hit_way_i;
            if (eval_wr_s) begin
               we_o         = 1'b1;
               wway_o       = hit_way_i;
               wflags_o     = eval_flags_s;
               invalidate_o = eval_inv_s;
               state_s      = gnt_i ? RESP : UPD;
            end else begin
               state_s = RESP;
            end
         end
         UPD: begin
            req_o        = hit_way_r;
            we_o         = 1'b1;
            wway_o       = hit_way_r;
            wflags_o     = wflags_r;
            invalidate_o = inv_r;
            if (gnt_i) begin
               state_s = RESP;
            end else begin
               state_s = UPD;
            end
         end
         RESP: begin
            if (cr_fin_s && cd_fin_s) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Snoop capture, lookup result latching and CR/CD progress tracking.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         index_r   <= '0;
         tag_r     <= '0;
         snoop_r   <= 4'b0000;
         hit_way_r <= '0;
         resp_r    <= 5'b00000;
         wflags_r  <= 3'b000;
         inv_r     <= 1'b0;
         buf_r     <= '0;
         beat_r    <= '0;
         cr_done_r <= 1'b0;
         cd_done_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  index_r   <= snp.ac_addr_i[IndexWidth-1:0];
                  tag_r     <= snp.ac_addr_i[IndexWidth +: TagWidth];
                  snoop_r   <= snp.ac_snoop_i;
                  resp_r    <= {3'b000, ~is_supported(snp.ac_snoop_i), 1'b0};
                  beat_r    <= '0;
                  cr_done_r <= 1'b0;
                  cd_done_r <= 1'b0;
               end
            end
            EVAL: begin
               // dirty/shared survive only through the derived response bits
               hit_way_r <= hit_way_i;
               resp_r    <= eval_resp_s;
               wflags_r  <= eval_flags_s;
               inv_r     <= eval_inv_s;
               buf_r     <= line_s;
            end
            RESP: begin
               if (cr_fire_s) begin
                  cr_done_r <= 1'b1;
               end
               if (cd_fire_s) begin
                  beat_r <= last_s ? '0 : beat_r + BeatW'(1);
                  if (last_s) begin
                     cd_done_r <= 1'b1;
                  end
               end
            end
            default: begin
               beat_r <= beat_r;
            end
         endcase
      end
   end

`ifdef SNOOP_PERF_CNT_EN
   logic [31:0] perf_hit_r;
   logic [31:0] perf_miss_r;

   // Saturating hit/miss counters for snoops that reach the lookup result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_hit_r  <= 32'd0;
         perf_miss_r <= 32'd0;
      end else if (state_r == EVAL) begin
         if (hit_s) begin
            if (perf_hit_r != 32'hFFFF_FFFF) begin
               perf_hit_r <= perf_hit_r + 32'd1;
            end
         end else if (perf_miss_r != 32'hFFFF_FFFF) begin
            perf_miss_r <= perf_miss_r + 32'd1;
         end
      end
   end

   assign perf_hit_o  = perf_hit_r;
   assign perf_miss_o = perf_miss_r;
`endif

   assign busy_o            = (state_r != IDLE);
   assign snp.ac_ready_o    = accept_s;
   assign snp.cr_valid_o    = (state_r == RESP) & ~cr_done_r;
   assign snp.cr_resp_o     = resp_r;
   assign snp.cd_valid_o    = (state_r == RESP) & resp_r[0] & ~cd_done_r;
   assign snp.cd_data_o     = snp.cd_valid_o ? buf_r[beat_r] : '0;
   assign snp.cd_last_o     = snp.cd_valid_o & last_s;
   assign addr_o            = accept_s ? snp.ac_addr_i[IndexWidth-1:0] : index_r;
   assign tag_o             = tag_r;
   assign invalidate_addr_o = invalidate_o ? line_addr_s : 64'd0;
   assign rs_done_valid_o   = we_o & gnt_i & (snoop_r == SNP_READ_SHARED);
   assign rs_done_addr_o    = rs_done_valid_o ? line_addr_s : 64'd0;

endmodule
